// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and
// the status-flag helper used by both the single-cycle and multiply paths.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Z/N come from the value actually written to the result register; the
  // result is passed zero-extended to 64 bits so one helper serves any WIDTH.
  function automatic flags_t calc_flags(input logic [63:0] res,
                                        input logic [5:0]  msb,
                                        input logic        ovf);
    flags_t f;
    f.z = (res == 64'd0);
    f.n = res[msb];
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// done and product are the combinational view of the final step, so the
// caller can register the result on the same edge the last step completes.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;

  // Partial product for the current multiplier bit and the accumulator after this step.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}};
    w_acc_next = r_acc + w_addend;
  end

  assign done    = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign product = w_acc_next;

  // Load operands on start, then shift-add once per cycle until WIDTH steps are done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_run    <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_run <= 1'b0;
      end else begin
        r_run <= 1'b1;
      end
    end else begin
      r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered datapath ALU with valid/ready input handshake, one-cycle
// out_valid pulse, Z/N/V status register and an iterative multiply op.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             out_valid,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_out;
  logic               r_z;
  logic               r_n;
  logic               r_v;
  logic               r_out_valid;
  logic               r_busy;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  flags_t             w_sc_flags;
  flags_t             w_mul_flags;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready    = (r_state == IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (ALUop == OP_MUL);

  assign out       = r_out;
  assign Z         = r_z;
  assign N         = r_n;
  assign V         = r_v;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (Ain),
    .b       (Bin),
    .done    (w_mul_done),
    .product (w_prod)
  );

  // Single-cycle result and signed-overflow selection; reserved ops yield zero.
  always_comb begin
    w_sum  = Ain + Bin;
    w_diff = Ain - Bin;
    w_res  = {WIDTH{1'b0}};
    w_ovf  = 1'b0;
    case (ALUop)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (Ain[MSB] == Bin[MSB]) && (w_sum[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (Ain[MSB] != Bin[MSB]) && (w_diff[MSB] != Ain[MSB]);
      end
      OP_AND: begin
        w_res = Ain & Bin;
        w_ovf = 1'b0;
      end
      OP_NOT: begin
        w_res = ~Bin;
        w_ovf = 1'b0;
      end
      default: begin
        w_res = {WIDTH{1'b0}};
        w_ovf = 1'b0;
      end
    endcase
    w_sc_flags  = calc_flags(64'(w_res), 6'(MSB), w_ovf);
    w_mul_flags = calc_flags(64'(w_prod[WIDTH-1:0]), 6'(MSB),
                             |w_prod[2*WIDTH-1:WIDTH]);
  end

  // Control FSM: accepts ops in IDLE, waits for the multiplier in MUL, and owns all result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out       <= {WIDTH{1'b0}};
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mul_start) begin
            r_state <= MUL;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_out       <= w_res;
            r_z         <= w_sc_flags.z;
            r_n         <= w_sc_flags.n;
            r_v         <= w_sc_flags.v;
            r_out_valid <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        MUL: begin
          if (w_mul_done) begin
            r_out       <= w_prod[WIDTH-1:0];
            r_z         <= w_mul_flags.z;
            r_n         <= w_mul_flags.n;
            r_v         <= w_mul_flags.v;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 16-bit and an 8-bit instance share clock
// and reset; stimulus pushes expected results, a monitor pops on out_valid.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v16, rdy16, ov16, z16, n16, f16, busy16;
  logic [15:0] a16, b16, o16;
  logic [2:0]  op16;
  logic        v8, rdy8, ov8, z8, n8, f8, busy8;
  logic [7:0]  a8, b8, o8;
  logic [2:0]  op8;

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst), .in_valid(v16), .in_ready(rdy16),
    .Ain(a16), .Bin(b16), .ALUop(op16), .out(o16),
    .Z(z16), .N(n16), .V(f16), .out_valid(ov16), .busy(busy16)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(v8), .in_ready(rdy8),
    .Ain(a8), .Bin(b8), .ALUop(op8), .out(o8),
    .Z(z8), .N(n8), .V(f8), .out_valid(ov8), .busy(busy8)
  );

  typedef struct {
    logic [15:0] o;
    logic        z;
    logic        n;
    logic        v;
    int          c;
    string       nm;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16;
  exp_t e8;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result, including its cycle.
  always @(negedge clk) begin
    if (ov16) begin
      if (q16.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_valid16: got out=%0h expected no result", o16);
      end else begin
        e16 = q16.pop_front();
        chk({e16.nm, "_out"}, 64'(o16), 64'(e16.o));
        chk({e16.nm, "_z"}, 64'(z16), 64'(e16.z));
        chk({e16.nm, "_n"}, 64'(n16), 64'(e16.n));
        chk({e16.nm, "_v"}, 64'(f16), 64'(e16.v));
        chk({e16.nm, "_cycle"}, 64'(cyc), 64'(e16.c));
      end
    end
    if (ov8) begin
      if (q8.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_valid8: got out=%0h expected no result", o8);
      end else begin
        e8 = q8.pop_front();
        chk({e8.nm, "_out"}, 64'(o8), 64'(e8.o[7:0]));
        chk({e8.nm, "_z"}, 64'(z8), 64'(e8.z));
        chk({e8.nm, "_n"}, 64'(n8), 64'(e8.n));
        chk({e8.nm, "_v"}, 64'(f8), 64'(e8.v));
        chk({e8.nm, "_cycle"}, 64'(cyc), 64'(e8.c));
      end
    end
  end

  // Present an op, hold it until in_ready, then record the expected response
  // (lat = edges from accept to result write). waited = cycles held off.
  task automatic issue(input bit w8, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic ez, input logic en,
                       input logic ev, input int lat, input bit push,
                       input string nm, output int waited);
    exp_t e;
    @(negedge clk);
    if (w8) begin
      v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v16 = 1'b1; op16 = op; a16 = a; b16 = b;
    end
    waited = 0;
    while (!(w8 ? rdy8 : rdy16) && waited < 100) begin
      chk({nm, "_busy_while_held"}, 64'(w8 ? busy8 : busy16), 64'd1);
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) chk({nm, "_ready_timeout"}, 64'(waited), 64'd0);
    if (push) begin
      e.o = eo; e.z = ez; e.n = en; e.v = ev; e.c = cyc + 1 + lat; e.nm = nm;
      if (w8) q8.push_back(e);
      else    q16.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v16 = 1'b0;
    v8  = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q16.size() != 0 || q8.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_pending"}, 64'(q16.size() + q8.size()), 64'd0);
  endtask

  int w;

  initial begin
    rst = 1'b1;
    v16 = 1'b0; a16 = 16'd0; b16 = 16'd0; op16 = OP_ADD;
    v8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;  op8  = OP_ADD;
    repeat (2) @(negedge clk);
    chk("rst_out16", 64'(o16), 64'd0);
    chk("rst_flags16", 64'({z16, n16, f16}), 64'd0);
    chk("rst_valid16", 64'(ov16), 64'd0);
    chk("rst_ready16", 64'(rdy16), 64'd1);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_ready8", 64'(rdy8), 64'd1);
    chk("rst_busy8", 64'(busy8), 64'd0);
    rst = 1'b0;

    // 16-bit single-cycle ops, back to back
    issue(1'b0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 0, 1'b1, "add_ovf", w);
    issue(1'b0, OP_SUB, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, "sub_zero", w);
    issue(1'b0, OP_NOT, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, "not_ffff", w);
    issue(1'b0, OP_AND, 16'h8001, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 1'b1, "and_msb", w);
    issue(1'b0, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 0, 1'b1, "sub_ovf", w);
    issue(1'b0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, 1'b1, "sub_neg", w);
    issue(1'b0, 3'b101, 16'h0005, 16'h0006, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, "reserved", w);

    // 16-bit multiply with an ADD held on in_valid throughout busy
    issue(1'b0, OP_MUL, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b0, 1'b1, 16, 1'b1, "mul_ovf", w);
    issue(1'b0, OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 0, 1'b1, "add_after_mul", w);
    chk("mul16_hold_cycles", 64'(w), 64'd16);
    issue(1'b0, OP_MUL, 16'd12, 16'd11, 16'd132, 1'b0, 1'b0, 1'b0, 16, 1'b1, "mul_small", w);
    idle();

    // 8-bit instance
    issue(1'b1, OP_MUL, 16'd16, 16'd16, 16'h0000, 1'b1, 1'b0, 1'b1, 8, 1'b1, "mul8_ovf", w);
    issue(1'b1, OP_ADD, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1, 1'b1, 0, 1'b1, "add8_ovf", w);
    chk("mul8_hold_cycles", 64'(w), 64'd8);
    issue(1'b1, OP_MUL, 16'd15, 16'd17, 16'h00FF, 1'b0, 1'b1, 1'b0, 8, 1'b1, "mul8_full", w);
    idle();
    drain("main");

    // Reset in the middle of a 16-bit multiply aborts it
    issue(1'b0, OP_MUL, 16'd5, 16'd5, 16'd25, 1'b0, 1'b0, 1'b0, 16, 1'b0, "mul_abort", w);
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy16", 64'(busy16), 64'd0);
    chk("abort_ready16", 64'(rdy16), 64'd1);
    chk("abort_out16", 64'(o16), 64'd0);
    chk("abort_flags16", 64'({z16, n16, f16}), 64'd0);
    chk("abort_out8", 64'(o8), 64'd0);
    repeat (20) @(negedge clk);
    issue(1'b0, OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 0, 1'b1, "add_after_abort", w);
    idle();
    drain("final");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor to the 16-bit datapath ALU. It adds a valid/ready input handshake, a registered result with an out_valid pulse, and a three-flag status register (Z, N, V). It also adds an iterative shift-add multiply op. The block sits in the datapath between the A/B operand registers and the C register/status register, and the controller FSM waits on out_valid for multi-cycle ops.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operands/op presented this cycle
in_ready  out  1  block can accept an op this cycle
Ain  in  WIDTH  operand A
Bin  in  WIDTH  operand B
ALUop  in  3  operation select (encoding in alu_pkg)
out  out  WIDTH  registered result
Z  out  1  result == 0
N  out  1  result MSB
V  out  1  signed overflow (ADD/SUB) / unsigned product overflow (MUL)
out_valid  out  1  one-cycle pulse: out and flags updated this cycle
busy  out  1  multiply in progress

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: out=0, Z=0, N=0, V=0, out_valid=0, busy=0, in_ready=1, FSM->IDLE, mul counter=0.
- Accept: an op is accepted on a rising edge where in_valid && in_ready. Ain/Bin/ALUop are captured at that edge.
- Op encoding:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND: A&B.
  - 011 NOT: ~B (A ignored).
  - 100 MUL: low WIDTH bits of A*B, unsigned.
  - 101..111 reserved: out=0, Z=1, N=0, V=0; latency as single-cycle ops.
- Arithmetic is modulo 2^WIDTH. There is no carry output.
- V for ADD: A[MSB]==B[MSB] && out[MSB]!=A[MSB].
- V for SUB: A[MSB]!=B[MSB] && out[MSB]!=A[MSB].
- V for AND/NOT: 0.
- V for MUL: 1 if any of the upper WIDTH bits of the 2*WIDTH-bit product is nonzero.
- Z = (out==0). N = out[WIDTH-1]. Flags are computed from the same value written to out.
- FSM states:
  - IDLE: in_ready=1. Single-cycle op accepted at edge k -> out/flags registered at edge k, out_valid=1 during cycle k+1; stay in IDLE. Back-to-back single-cycle ops give one result per cycle. MUL accepted -> MUL state, busy=1, in_ready=0.
  - MUL: one shift-add step per cycle, WIDTH steps total. MUL accepted at edge k -> last step at edge k+WIDTH; out/flags written at edge k+WIDTH, out_valid=1 during cycle k+WIDTH+1; return to IDLE (in_ready=1 in that same cycle).
- in_ready is combinational from state only (IDLE). It does not depend on in_valid.
- in_valid while busy is ignored; no queuing.
- out, Z, N, V hold their value until the next result write. out_valid is low on all other cycles.
- Reset asserted mid-MUL aborts the op: no out_valid, all outputs return to reset values on that edge.
- Reset has priority over accept on the same edge.

Decomposition:
- alu_pkg: ALUop localparams (OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_MUL), FSM state typedef (IDLE, MUL), and a flag-calculation function shared by both paths.
- Sub-module alu_mul_iter (WIDTH): shift-add multiplier.
  - Inputs: clk, reset, start, a, b.
  - Outputs: done pulse, 2*WIDTH-bit product.
  - alu_seq instantiates it and owns the handshake and flag logic.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out=0, Z=N=V=0, out_valid=0, in_ready=1, busy=0.
- ADD, WIDTH=16: A=0x7FFF, B=0x0001 -> out=0x8000, N=1, V=1, Z=0, out_valid exactly 1 cycle after accept. Then SUB A=7, B=7 on the next cycle -> out=0, Z=1, back-to-back pulses.
- NOT and AND: NOT with B=0xFFFF -> out=0, Z=1. AND with A=0x8001, B=0x8000 -> out=0x8000, N=1, Z=0.
- MUL: A=300, B=300 -> out=0x5F90 (90000 mod 65536), V=1, busy for 16 cycles, out_valid exactly 17 cycles after accept. in_valid held high with an ADD during busy -> ignored; the ADD is accepted only in the cycle out_valid is high.
- MUL no-overflow: A=12, B=11 -> out=132, V=0. Repeat with WIDTH=8: A=16, B=16 -> out=0, Z=1, V=1, latency 9.
- Reset at cycle 5 of a MUL -> no out_valid afterwards, busy=0, in_ready=1; a following ADD 1+1 -> out=2.
